// File: rtl/frame_rd_ctrl_if.sv
// Memory read-command port and external PipeOut FIFO write port of frame_rd_ctrl.
// Handshake: mem_rd_req rises with a stable mem_rd_addr and stays high until the
// cycle mem_rd_ack is sampled high. That cycle transfers one BURST_LEN-word command,
// and req is low the next cycle. Read data returns later on mem_rdata_valid, with no back-pressure.
interface frame_rd_ctrl_if #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 24,
    parameter int FIFO_CNT_W = 10
);
    logic                  mem_rd_req;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic                  mem_rd_ack;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rdata_valid;
    logic                  fifo_clr;
    logic                  fifo_wr_en;
    logic [DATA_W-1:0]     fifo_din;
    logic [FIFO_CNT_W-1:0] fifo_wr_count;

    modport master (
        output mem_rd_req, mem_rd_addr, fifo_clr, fifo_wr_en, fifo_din,
        input  mem_rd_ack, mem_rdata, mem_rdata_valid, fifo_wr_count
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, fifo_clr, fifo_wr_en, fifo_din,
        output mem_rd_ack, mem_rdata, mem_rdata_valid, fifo_wr_count
    );
endinterface

// File: rtl/frame_rd_ctrl.sv
// DDR->host window readout: fixed bursts per row with FIFO credit flow control and abort.
// Optional FRAME_RD_BYTESWAP_EN reverses byte order within each 64-bit word of fifo_din.
module frame_rd_ctrl #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 1024,
    parameter int FIFO_CNT_W = 10,
    parameter int MARGIN     = 64
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W+2:0] base_addr,
    input  logic [23:0]       row_bytes,
    input  logic [15:0]       rows,
    input  logic [23:0]       stride_bytes,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg,
    frame_rd_ctrl_if.master   bus
);
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int OUT_W       = 17;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        NEXT_ROW = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [23:0]       row_bytes_q;
    logic [23:0]       row_rem;
    logic [15:0]       rows_rem;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] stride_words;
    logic [OUT_W-1:0]  outstanding;
    logic              aborting;
    logic [DATA_W-1:0] din_fmt;

    logic              geom_zero, ack_take, row_last, credit_ok, stop, discard;
    logic [OUT_W:0]    credit_need;
    logic              unused_ok;

    assign unused_ok   = ^{base_addr[2:0]};
    assign geom_zero   = (rows == 16'd0) || (row_bytes == 24'd0);
    assign ack_take    = (state == WAIT_ACK) && bus.mem_rd_ack;
    assign row_last    = row_rem <= 24'(BURST_BYTES);
    assign credit_need = (OUT_W+1)'(bus.fifo_wr_count) + (OUT_W+1)'(outstanding)
                       + (OUT_W+1)'(BURST_LEN);
    assign credit_ok   = credit_need <= (OUT_W+1)'(FIFO_DEPTH - MARGIN);
    assign stop        = aborting || abort;
    // Words landing after an abort belong to a cancelled window and are dropped.
    assign discard     = aborting || (abort && busy);

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && !geom_zero) state_nxt = ISSUE;
            ISSUE: begin
                if (stop)                               state_nxt = DRAIN;
                else if (credit_ok && !bus.mem_rd_ack)  state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.mem_rd_ack)
                    state_nxt = stop ? DRAIN : (row_last ? NEXT_ROW : ISSUE);
            end
            NEXT_ROW: state_nxt = (stop || rows_rem <= 16'd1) ? DRAIN : ISSUE;
            DRAIN:    if (outstanding == '0) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        bus.mem_rd_req = (state == WAIT_ACK);
        bus.fifo_clr   = (state == IDLE);
        state_dbg      = state;
    end

`ifdef FRAME_RD_BYTESWAP_EN
    always_comb begin
        din_fmt = '0;
        for (int w = 0; w < DATA_W / 64; w++)
            for (int b = 0; b < 8; b++)
                din_fmt[w*64 + b*8 +: 8] = bus.mem_rdata[w*64 + (7-b)*8 +: 8];
    end
`else
    assign din_fmt = bus.mem_rdata;
`endif

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            done            <= 1'b0;
            row_bytes_q     <= '0;
            row_rem         <= '0;
            rows_rem        <= '0;
            row_addr        <= '0;
            stride_words    <= '0;
            outstanding     <= '0;
            aborting        <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.fifo_wr_en  <= 1'b0;
            bus.fifo_din    <= '0;
        end else begin
            done <= ((state == IDLE) && start && geom_zero)
                 || ((state == DRAIN) && (outstanding == '0));

            // Ack and returning data in the same cycle net into one update.
            case ({ack_take, bus.mem_rdata_valid && (outstanding != '0)})
                2'b10:   outstanding <= outstanding + OUT_W'(BURST_LEN);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                2'b11:   outstanding <= outstanding + OUT_W'(BURST_LEN - 1);
                default: ;
            endcase

            if (state == IDLE) begin
                aborting <= 1'b0;
                if (start) begin
                    row_bytes_q     <= row_bytes;
                    row_rem         <= row_bytes;
                    rows_rem        <= rows;
                    stride_words    <= ADDR_W'(stride_bytes >> 3);
                    row_addr        <= base_addr[ADDR_W+2:3];
                    bus.mem_rd_addr <= base_addr[ADDR_W+2:3];
                end
            end else if (abort) begin
                aborting <= 1'b1;
            end

            // A partial last burst still fetches a full burst; the row just ends.
            if (ack_take) begin
                bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_W'(BURST_LEN);
                row_rem         <= row_last ? 24'd0 : row_rem - 24'(BURST_BYTES);
            end

            if (state == NEXT_ROW) begin
                rows_rem        <= rows_rem - 16'd1;
                row_addr        <= row_addr + stride_words;
                bus.mem_rd_addr <= row_addr + stride_words;
                row_rem         <= row_bytes_q;
            end

            bus.fifo_wr_en <= bus.mem_rdata_valid && !discard;
            if (bus.mem_rdata_valid) bus.fifo_din <= din_fmt;
        end
    end
endmodule
